// File: rtl/uart_digit_scheduler_if.sv
// UART-side handshake bundle: received byte strobe in, acknowledge byte out with valid/ready.
interface uart_digit_scheduler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ack_drop;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, ack_drop
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, ack_drop
  );
endinterface

// File: rtl/uart_digit_scheduler.sv
// ASCII digits -> 4-digit multiplexed 7-segment display; bytes take effect on the accepting edge, ack visible next cycle.
// rx is never stalled; the single-entry ack slot drops (and flags) a new ack when full and not draining.
module uart_digit_scheduler #(
  parameter int SCAN_DIV       = 27000,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_digit_scheduler_if.slave bus,
  output logic [6:0]            seg,
  output logic [3:0]            an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state_q, state_d;
  logic [15:0]       pend_q, pend_d;
  logic [15:0]       disp_q, disp_d;
  logic [2:0]        pcnt_q, pcnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              ack_drop_q, ack_drop_d;

  logic              ack_req;
  logic [7:0]        ack_byte;
  logic              is_digit;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 7'b0111111;
      4'd1:    enc = 7'b0000110;
      4'd2:    enc = 7'b1011011;
      4'd3:    enc = 7'b1001111;
      4'd4:    enc = 7'b1100110;
      4'd5:    enc = 7'b1101101;
      4'd6:    enc = 7'b1111101;
      4'd7:    enc = 7'b0000111;
      4'd8:    enc = 7'b1111111;
      4'd9:    enc = 7'b1101111;
      default: enc = 7'b0000000;
    endcase
  endfunction

  assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);

  // Byte parser / pending buffer FSM; a byte in the expiry cycle wins over the timeout.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    pcnt_d   = pcnt_q;
    to_d     = to_q;
    ack_req  = 1'b0;
    ack_byte = 8'h00;
    if (bus.rx_valid) begin
      to_d = '0;
      if (is_digit) begin
        pend_d  = {pend_q[11:0], bus.rx_data[3:0]};
        pcnt_d  = (pcnt_q == 3'd4) ? 3'd4 : pcnt_q + 3'd1;
        state_d = COLLECT;
      end else if (bus.rx_data == 8'h0D) begin
        ack_req = 1'b1;
        if (pcnt_q != 3'd0) begin
          for (int i = 0; i < 4; i++) begin
            disp_d[i*4 +: 4] = (3'(i) < pcnt_q) ? pend_q[i*4 +: 4] : 4'hF;
          end
          pend_d   = 16'hFFFF;
          pcnt_d   = 3'd0;
          state_d  = IDLE;
          ack_byte = ACK_OK;
        end else begin
          ack_byte = ACK_ERR;
        end
      end else if (bus.rx_data == 8'h43) begin
        pend_d  = 16'hFFFF;
        pcnt_d  = 3'd0;
        state_d = IDLE;
      end else begin
        ack_req  = 1'b1;
        ack_byte = ACK_ERR;
      end
    end else if (state_q == COLLECT) begin
      if (to_q == TO_LAST) begin
        to_d    = '0;
        pend_d  = 16'hFFFF;
        pcnt_d  = 3'd0;
        state_d = IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  // Ack slot: a handshake in the same cycle frees the slot for a new ack.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q && !bus.tx_ready;
    ack_drop_d = 1'b0;
    if (ack_req) begin
      if (!tx_valid_q || bus.tx_ready) begin
        tx_data_d  = ack_byte;
        tx_valid_d = 1'b1;
      end else begin
        ack_drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    an_d  = 4'b0001 << idx_q;
    seg_d = enc(disp_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 16'hFFFF;
      disp_q     <= 16'hFFFF;
      pcnt_q     <= 3'd0;
      to_q       <= '0;
      div_q      <= '0;
      idx_q      <= 2'd0;
      an_q       <= 4'b0001;
      seg_q      <= 7'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ack_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      pcnt_q     <= pcnt_d;
      to_q       <= to_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ack_drop_q <= ack_drop_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.ack_drop = ack_drop_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: tb/tb_uart_digit_scheduler.sv
// Directed bench for uart_digit_scheduler: acks checked by a queue-based scoreboard, display checked via the scan outputs.
module tb_uart_digit_scheduler;

  localparam int SCAN_DIV = 8;
  localparam int TIMEOUT  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [3:0] an;

  uart_digit_scheduler_if bus_if ();

  uart_digit_scheduler #(
    .SCAN_DIV       (SCAN_DIV),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int         checks     = 0;
  int         errors     = 0;
  int         handshakes = 0;
  int         drops      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 7'b0111111;
      4'd1:    enc = 7'b0000110;
      4'd2:    enc = 7'b1011011;
      4'd3:    enc = 7'b1001111;
      4'd4:    enc = 7'b1100110;
      4'd5:    enc = 7'b1101101;
      4'd6:    enc = 7'b1111101;
      4'd7:    enc = 7'b0000111;
      4'd8:    enc = 7'b1111111;
      4'd9:    enc = 7'b1101111;
      default: enc = 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest queued ack.
  always @(negedge clk) begin
    if (!reset && bus_if.ack_drop) drops++;
    if (!reset && bus_if.tx_valid && bus_if.tx_ready) begin
      handshakes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got 0x%0h expected no handshake", bus_if.tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_if.tx_data !== mon_exp) begin
          errors++;
          $display("FAIL ack_data: got 0x%0h expected 0x%0h", bus_if.tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Drives the byte from posedge+1; it is accepted at the following posedge.
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_an(input logic [3:0] target, output bit found);
    found = 1'b0;
    for (int c = 0; c < SCAN_DIV * 5 && !found; c++) begin
      @(negedge clk);
      if (an == target) found = 1'b1;
    end
  endtask

  task automatic check_disp(input string name, input logic [15:0] exp);
    bit found;
    for (int i = 0; i < 4; i++) begin
      wait_an(4'b0001 << i, found);
      check($sformatf("%s_an%0d", name, i), found, 1'b1);
      check($sformatf("%s_seg%0d", name, i), seg, enc(exp[i*4 +: 4]));
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    int drops_before;
    reset           = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", seg, 7'd0);
    check("rst_an", an, 4'b0001);
    check("rst_tx_valid", bus_if.tx_valid, 1'b0);
    check("rst_tx_data", bus_if.tx_data, 8'h00);
    check("rst_ack_drop", bus_if.ack_drop, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      wait_an(4'b0001 << (k % 4), found);
      check($sformatf("walk_an%0d", k), found, 1'b1);
      check($sformatf("walk_seg%0d", k), seg, 7'd0);
    end

    exp_q.push_back(8'h4B);
    send_str("12\r");
    wait_drain("commit_ack");
    check_disp("commit", 16'hFF12);

    exp_q.push_back(8'h4B);
    send_str("98765\r");
    wait_drain("overflow_ack");
    check_disp("overflow", 16'h8765);

    exp_q.push_back(8'h45);
    send_str("\r");
    exp_q.push_back(8'h45);
    send_str("Z");
    exp_q.push_back(8'h45);
    send_str("4C\r");
    wait_drain("errors_ack");
    check_disp("errors", 16'h8765);

    // After send() returns, k idle edges put the next byte at accept edge +2+k.
    exp_q.push_back(8'h45);
    send_str("3");
    repeat (99) @(posedge clk);
    send_str("\r");
    wait_drain("timeout_late_ack");
    check_disp("timeout_late", 16'h8765);

    exp_q.push_back(8'h4B);
    send_str("3");
    repeat (98) @(posedge clk);
    send_str("\r");
    wait_drain("timeout_exact_ack");
    check_disp("timeout_exact", 16'hFFF3);

    bus_if.tx_ready = 1'b0;
    drops_before    = drops;
    exp_q.push_back(8'h4B);
    send_str("1\rQ");
    repeat (4) @(negedge clk);
    check("bp_tx_valid", bus_if.tx_valid, 1'b1);
    check("bp_tx_data", bus_if.tx_data, 8'h4B);
    check("bp_drop_count", drops - drops_before, 1);
    check_disp("bp", 16'hFFF1);
    check("bp_tx_data_hold", bus_if.tx_data, 8'h4B);
    @(posedge clk);
    #1;
    bus_if.tx_ready = 1'b1;
    wait_drain("bp_ack");
    @(negedge clk);
    check("bp_tx_valid_clear", bus_if.tx_valid, 1'b0);

    bus_if.tx_ready = 1'b0;
    send_str("5\r7");
    @(negedge clk);
    check("mid_tx_valid_pre", bus_if.tx_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_tx_valid", bus_if.tx_valid, 1'b0);
    check("mid_tx_data", bus_if.tx_data, 8'h00);
    check("mid_an", an, 4'b0001);
    check("mid_seg", seg, 7'd0);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus_if.tx_ready = 1'b1;
    check_disp("mid_disp", 16'hFFFF);
    exp_q.push_back(8'h45);
    send_str("\r");
    wait_drain("mid_pend_cleared");

    repeat (3) @(negedge clk);
    check("total_handshakes", handshakes, 9);
    check("total_drops", drops, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_digit_scheduler.md
# uart_digit_scheduler

Sits between the UART byte receiver and the 7-segment pins, and replaces the single-digit direct decode with a 4-digit display.
- Parses received ASCII bytes into a pending digit buffer and commits it on carriage return.
- Time-multiplexes the committed digits onto one shared segment bus.
- Returns a one-byte acknowledge through a valid/ready handshake to the UART transmitter.

## Interface
- `SCAN_DIV`, default 27000: clock cycles each digit stays selected (1 kHz per digit at 27 MHz).
- `TIMEOUT_CYCLES`, default 27000000: idle cycles in COLLECT before pending digits are discarded (1 s at 27 MHz).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data` out 8: acknowledge byte.
- `tx_valid` out 1: `tx_data` is pending.
- `tx_ready` in 1: transmitter accepts `tx_data` when `tx_valid` and `tx_ready` are both 1.
- `ack_drop` out 1: one-cycle pulse when an ack is lost because the slot is full.
- `seg` out 7: segment pattern, bit order {g,f,e,d,c,b,a}, active-high.
- `an` out 4: digit select, one-hot, active-high; `an[0]` is the rightmost digit.

## Operation
- **Storage**
  - `pend[3:0]` and `disp[3:0]` each hold four 4-bit nibbles. Nibble 0–9 is a digit; 0xF is blank.
  - `pcnt` is 0–4 and counts valid pending digits.
- **States**
  - IDLE: `pcnt` == 0.
  - COLLECT: one or more digits pending.
- **Byte handling**, applied on the cycle where `rx_valid` = 1:
  - 0x30–0x39: shift left, `pend <= {pend[2:0], byte-0x30}`, `pcnt <= min(pcnt+1,4)`, go to COLLECT.
  - A 5th or later digit drops the oldest digit; only the last four digits are kept.
  - 0x0D with `pcnt` > 0: `disp <= pend`, with the unfilled upper nibbles set to 0xF (right-aligned, leading blanks). Clear `pend` to all 0xF and `pcnt` to 0, go to IDLE, queue ack 0x4B ('K').
  - 0x0D with `pcnt` == 0: `disp` is unchanged; queue ack 0x45 ('E').
  - 0x43 ('C'): clear `pend` and `pcnt`, go to IDLE, no ack.
  - Any other byte: queue 'E'; `pend`, `pcnt` and the state are unchanged.
- **Timeout**
  - The counter runs only in COLLECT and resets to 0 on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`-1: clear `pend`/`pcnt`, go to IDLE, no ack.
  - If `rx_valid` arrives in the same cycle as expiry, the byte is processed and the timeout is ignored.
- **Ack slot**, single entry:
  - A queued ack loads `tx_data` and sets `tx_valid` if the slot is empty, or if it is being emptied that cycle (`tx_valid` && `tx_ready`).
  - Otherwise the new ack is discarded, `tx_data` is unchanged, and `ack_drop` pulses.
  - `tx_valid` clears after a handshake unless it is reloaded in the same cycle.
  - `tx_data` stays stable while `tx_valid` = 1.
- **Scan**
  - The divider counts 0 to `SCAN_DIV`-1. On wrap, `idx <= idx+1` modulo 4.
  - The `an` and `seg` registers follow `idx` one cycle later: `an = 1<<idx`, `seg = enc(disp[idx])`.
  - enc values (7-bit {g,f,e,d,c,b,a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Blank or 0xA–0xE gives 0000000.

## Timing
- **Reset values**
  - `seg`=0, `an`=4'b0001, `tx_valid`=0, `tx_data`=0, `ack_drop`=0.
  - `disp`/`pend` all 0xF, `pcnt`=0, state IDLE, `idx`=0, divider and timeout counters 0.
  - Reset asserted mid-operation forces all of the above immediately, discards the pending ack, and takes effect regardless of `clk`.
- **Latency**
  - Byte accepted at edge N: `pend`/`disp`/state update at edge N.
  - `tx_valid` rises at edge N (visible in cycle N+1).
  - `seg` reflects the new `disp` at the next scan-register update, at most 1 cycle later when the digit is currently selected.
- **Throughput**
  - One byte per cycle is accepted; back-to-back `rx_valid` is legal.
  - The ack slot is the only back-pressure point; `rx` is never stalled.

## Test plan
- **Reset:** assert `reset` for 3 cycles → `seg`=0, `an`=0001, `tx_valid`=0; after `SCAN_DIV`×4 cycles `an` has walked 0001→0010→0100→1000→0001 with `seg`=0 throughout.
- **Commit:** send "12\r" with `tx_ready`=1 → `disp`={F,F,1,2}; `an`=0001 gives `seg`=1011011, `an`=0010 gives `seg`=0000110; one handshake with `tx_data`=0x4B.
- **Overflow:** send "98765\r" → `disp`={8,7,6,5}, ack 'K'.
- **Errors and clear:** "\r" with nothing pending → 'E' and `disp` unchanged; "Z" → 'E'; "4C\r" → 'E', `disp` unchanged.
- **Timeout:** with `TIMEOUT_CYCLES`=100, send "3", idle 100 cycles, then "\r" → 'E' and `disp` unchanged. Repeat with the "\r" arriving exactly at the expiry cycle → 'K' and `disp`={F,F,F,3}.
- **Back-pressure:** hold `tx_ready`=0 and send "1\r" then "Q" → `tx_data` stays 0x4B and `ack_drop` pulses once. Raise `tx_ready` → one handshake, then `tx_valid`=0.
